// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - display geometry, SSD-style window opcodes and streamer FSM states
package oled_pkg;

    localparam int OLED_COLS   = 96;
    localparam int OLED_PAGES  = 8;
    localparam int OLED_NBYTES = OLED_COLS * OLED_PAGES;
    localparam int OLED_AW     = 10;

    localparam logic [7:0] CMD_SET_COL  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE = 8'h22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CMD_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_SEND_WAIT,
        ST_DONE
    } oled_state_t;

endpackage

// File: rtl/oled_frame_streamer.sv
// rtl/oled_frame_streamer.sv - sends the window preamble then the whole framebuffer over the SPI byte master
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int COLS   = OLED_COLS,
    parameter int PAGES  = OLED_PAGES,
    parameter int NBYTES = COLS * PAGES,
    parameter int AW     = OLED_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          oled_ready,
    input  logic          frame_start,
    output logic          busy,
    output logic          frame_done,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_data,
    output logic          spi_start,
    output logic [7:0]    spi_data,
    input  logic          spi_done,
    output logic          dc
);

    localparam logic [AW-1:0] LAST_BYTE = AW'(NBYTES - 1);
    localparam logic [2:0]    LAST_CMD  = 3'd5;
    localparam logic [7:0]    LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]    LAST_PAGE = 8'(PAGES - 1);

    oled_state_t     state;
    oled_state_t     next_state;
    logic [2:0]      cmd_idx;
    logic [AW-1:0]   byte_idx;
    logic            pending;
    logic            accept;

    // Addressing window covering the full panel: columns 0..COLS-1, pages 0..PAGES-1
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = CMD_SET_COL;
            3'd1:    cmd_byte = 8'h00;
            3'd2:    cmd_byte = LAST_COL;
            3'd3:    cmd_byte = CMD_SET_PAGE;
            3'd4:    cmd_byte = 8'h00;
            3'd5:    cmd_byte = LAST_PAGE;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    assign accept = oled_ready && (frame_start || pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (accept) next_state = ST_CMD;
            ST_CMD:       next_state = ST_CMD_WAIT;
            ST_CMD_WAIT:  if (spi_done) next_state = (cmd_idx == LAST_CMD) ? ST_FETCH : ST_CMD;
            ST_FETCH:     next_state = ST_LATCH;
            ST_LATCH:     next_state = ST_SEND;
            ST_SEND:      next_state = ST_SEND_WAIT;
            ST_SEND_WAIT: if (spi_done) next_state = (byte_idx == LAST_BYTE) ? ST_DONE : ST_FETCH;
            ST_DONE:      next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered so spi_data/dc stay put for the whole byte transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            spi_start  <= 1'b0;
            spi_data   <= 8'h00;
            dc         <= 1'b0;
            fb_addr    <= '0;
            pending    <= 1'b0;
            cmd_idx    <= '0;
            byte_idx   <= '0;
        end else begin
            spi_start  <= 1'b0;
            frame_done <= 1'b0;
            // Requests arriving mid-frame (including the DONE cycle) coalesce into one
            if (state != ST_IDLE && frame_start) pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        cmd_idx <= '0;
                        pending <= 1'b0;
                    end
                end
                ST_CMD: begin
                    dc        <= 1'b0;
                    spi_data  <= cmd_byte(cmd_idx);
                    spi_start <= 1'b1;
                end
                ST_CMD_WAIT: begin
                    if (spi_done) begin
                        if (cmd_idx == LAST_CMD) byte_idx <= '0;
                        else                     cmd_idx  <= cmd_idx + 3'd1;
                    end
                end
                ST_FETCH: fb_addr <= byte_idx;
                ST_SEND: begin
                    dc        <= 1'b1;
                    spi_data  <= fb_data;
                    spi_start <= 1'b1;
                end
                ST_SEND_WAIT: begin
                    if (spi_done && byte_idx != LAST_BYTE) byte_idx <= byte_idx + 1'b1;
                end
                ST_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// tb/tb_oled_frame_streamer.sv - directed self-checking bench for oled_frame_streamer
module tb_oled_frame_streamer;
    import oled_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       oled_ready;
    logic       frame_start;
    logic       busy;
    logic       frame_done;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       dc;

    always #5 clk = ~clk;

    oled_frame_streamer dut (
        .clk         (clk),
        .reset       (reset),
        .oled_ready  (oled_ready),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .spi_start   (spi_start),
        .spi_data    (spi_data),
        .spi_done    (spi_done),
        .dc          (dc)
    );

    // Synchronous framebuffer RAM holding addr[7:0]
    always @(posedge clk) fb_data <= fb_addr[7:0];

    logic [7:0] exp_cmd [6] = '{8'h21, 8'h00, 8'h5F, 8'h22, 8'h00, 8'h07};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          spi_lat = 16;
    bit          inject = 1'b0;
    logic [8:0]  cap [$];
    int          starts = 0;
    int          fd_count = 0;
    int          busy_cycles = 0;
    int          proto_err = 0;
    bit          outstanding = 1'b0;
    logic [7:0]  held_data;
    logic        held_dc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Byte logger and handshake protocol monitor
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 1'b0;
        end else begin
            if (frame_done) fd_count++;
            if (busy) busy_cycles++;
            if (outstanding && (spi_data !== held_data || dc !== held_dc)) proto_err++;
            if (spi_start) begin
                if (outstanding) proto_err++;
                outstanding = 1'b1;
                held_data   = spi_data;
                held_dc     = dc;
                starts++;
                cap.push_back({dc, spi_data});
            end else if (spi_done && outstanding) begin
                outstanding = 1'b0;
            end
        end
    end

    // SPI master model: spi_done spi_lat cycles after spi_start; optionally stretched into FETCH
    initial begin
        spi_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (spi_start) begin
                repeat (spi_lat) begin @(posedge clk); #1; end
                spi_done = 1'b1;
                @(posedge clk); #1;
                if (inject && dc) begin
                    @(posedge clk); #1;
                end
                spi_done = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int i = 0;
        while (starts < n && i < budget) begin tick(1); i++; end
        check("wait_starts_timeout", starts >= n, 1);
    endtask

    task automatic wait_frame_done(input int budget, output int at);
        int i = 0;
        at = -1;
        while (at < 0 && i < budget) begin
            @(negedge clk);
            if (frame_done) at = cyc;
            i++;
        end
        check("frame_done_timeout", at >= 0, 1);
    endtask

    task automatic check_frame(input int base, input string tag);
        int bad = 0;
        logic [8:0] got;
        for (int k = 0; k < 6; k++) begin
            got = (base + k < cap.size()) ? cap[base + k] : 9'h1FF;
            check({tag, "_cmd"}, got, {1'b0, exp_cmd[k]});
        end
        for (int j = 0; j < 768; j++) begin
            got = (base + 6 + j < cap.size()) ? cap[base + 6 + j] : 9'h1FF;
            if (got !== {1'b1, 8'(j)}) bad++;
        end
        check({tag, "_data_mismatches"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int at;
        int t0;
        reset       = 1'b1;
        oled_ready  = 1'b0;
        frame_start = 1'b0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_dc", dc, 0);
        check("rst_fb_addr", fb_addr, 0);
        reset = 1'b0;
        tick(2);

        // Full frame, slow SPI
        spi_lat = 16; oled_ready = 1'b1;
        cap.delete(); starts = 0; fd_count = 0;
        pulse_start();
        wait_frame_done(20000, at);
        check("t1_busy_after", busy, 0);
        tick(40);
        check("t1_starts", starts, 774);
        check("t1_frame_done_count", fd_count, 1);
        check_frame(0, "t1");
        check("t1_protocol", proto_err, 0);

        // Request while the panel is not ready is dropped
        oled_ready = 1'b0; starts = 0; busy_cycles = 0;
        pulse_start();
        tick(1000);
        check("t2_no_start", starts, 0);
        check("t2_no_busy", busy_cycles, 0);
        oled_ready = 1'b1;
        tick(50);
        check("t2_still_idle_starts", starts, 0);
        check("t2_still_idle_busy", busy_cycles, 0);

        // Back-to-back frames via pending, with spurious spi_done in FETCH
        spi_lat = 4; inject = 1'b1;
        cap.delete(); starts = 0; fd_count = 0;
        pulse_start();
        wait_starts(6 + 11, 2000);
        pulse_start();
        wait_starts(6 + 401, 8000);
        pulse_start();
        wait_frame_done(20000, at);
        check("t3_gap_idle", busy, 0);
        @(negedge clk);
        check("t3_gap_rebusy", busy, 1);
        wait_frame_done(20000, at);
        tick(100);
        check("t3_frames", fd_count, 2);
        check("t3_starts", starts, 2 * 774);
        check("t3_busy_after", busy, 0);
        check_frame(0, "t3a");
        check_frame(774, "t3b");
        check("t3_protocol", proto_err, 0);
        inject = 1'b0;

        // Reset while data byte 300 is in flight
        cap.delete(); starts = 0; fd_count = 0;
        pulse_start();
        wait_starts(6 + 301, 8000);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        t0 = starts;
        tick(200);
        check("t4_no_more_starts", starts, t0);
        check("t4_busy", busy, 0);
        check("t4_no_frame_done", fd_count, 0);
        cap.delete(); starts = 0;
        pulse_start();
        wait_frame_done(20000, at);
        tick(20);
        check("t4_restart_first", cap.size() > 0 ? cap[0] : 9'h1FF, 9'h021);
        check("t4_restart_starts", starts, 774);
        check_frame(0, "t4");
        check("t4_protocol", proto_err, 0);

        // Minimum SPI latency: the DUT idles at most 1 cycle around each command byte
        // (period L+2) and 3 cycles around each data byte (period L+4), plus 2 cycles
        // from request to first spi_start, so frame_done lands 2+6*3+768*5 = 3860 cycles
        // after the cycle frame_start is presented.
        spi_lat = 1;
        cap.delete(); starts = 0; fd_count = 0;
        t0 = cyc;
        pulse_start();
        wait_frame_done(20000, at);
        check("t5_cycles_in_tol", (at - t0 >= 3858) && (at - t0 <= 3862), 1);
        tick(20);
        check("t5_starts", starts, 774);
        check_frame(0, "t5");
        check("t5_protocol", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
